axi_mem_slave: RTL and testbench

//  AXI4 memory-mapped slave and backing store. Sits directly downstream of axi_driver and consumes its M_AXI_* master

---
 rtl/axi_mem_slave.sv | 180 ++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: one INCR burst at a time over a byte-strobed word array, with an FSM debug port.
// Optional feature: define AXI_MEM_RANGE_CHECK_EN to reject bursts that start beyond the end of memory.
module axi_mem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic [AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [1:0]                    dbg_state
);
    // Handshake rule on every channel: a transfer happens on a rising edge where valid && ready;
    // the sender holds valid and payload stable until then.
    localparam int LANES = AXI_DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, WRESP = 2'd2, RDATA = 2'd3} state_t;
    state_t state, state_nx;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDXW-1:0]           idx;
    logic [7:0]                len, beat;
    logic                      err, err_nx, oor;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_beat;
    logic                      aw_oor, ar_oor;
    logic [IDXW-1:0]           aw_idx, ar_idx;
    logic                      unused_ok;

    assign S_AXI_AWREADY = (state == IDLE);
    assign S_AXI_ARREADY = (state == IDLE) && !S_AXI_AWVALID;
    assign S_AXI_WREADY  = (state == WDATA);
    assign dbg_state     = state;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID && S_AXI_BREADY;
    assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;

    assign aw_idx      = S_AXI_AWADDR[OFFW +: IDXW];
    assign ar_idx      = S_AXI_ARADDR[OFFW +: IDXW];
    // The beat counter, not WLAST, decides where a write burst ends.
    assign w_last_beat = (beat == len);
    assign err_nx      = err || (S_AXI_WLAST != w_last_beat);

`ifdef AXI_MEM_RANGE_CHECK_EN
    assign aw_oor = |S_AXI_AWADDR[AXI_ADDR_WIDTH-1:OFFW+IDXW];
    assign ar_oor = |S_AXI_ARADDR[AXI_ADDR_WIDTH-1:OFFW+IDXW];
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Size/burst type are ignored and address bits outside the word index may be dropped.
    assign unused_ok = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWSIZE, S_AXI_AWBURST,
                         S_AXI_ARSIZE, S_AXI_ARBURST};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (S_AXI_AWVALID)      state_nx = WDATA;
                else if (S_AXI_ARVALID) state_nx = RDATA;
            end
            WDATA:   if (w_hs && w_last_beat) state_nx = WRESP;
            WRESP:   if (S_AXI_BREADY)        state_nx = IDLE;
            RDATA:   if (r_hs && S_AXI_RLAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_hs && !oor) begin
            for (int b = 0; b < LANES; b++) begin
                if (S_AXI_WSTRB[b]) mem[idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            len          <= '0;
            beat         <= '0;
            err          <= 1'b0;
            oor          <= 1'b0;
            id           <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= OKAY;
            S_AXI_BID    <= '0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RID    <= '0;
            S_AXI_RRESP  <= OKAY;
            S_AXI_RLAST  <= 1'b0;
        end else begin
            if (aw_hs) begin
                idx  <= aw_idx;
                len  <= S_AXI_AWLEN;
                id   <= S_AXI_AWID;
                beat <= '0;
                err  <= 1'b0;
                oor  <= aw_oor;
            end else if (ar_hs) begin
                // First beat is fetched here, so idx already points at the second beat.
                idx          <= ar_idx + IDXW'(1);
                len          <= S_AXI_ARLEN;
                beat         <= '0;
                oor          <= ar_oor;
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= ar_oor ? '0 : mem[ar_idx];
                S_AXI_RID    <= S_AXI_ARID;
                S_AXI_RRESP  <= ar_oor ? SLVERR : OKAY;
                S_AXI_RLAST  <= (S_AXI_ARLEN == 8'd0);
            end
            if (w_hs) begin
                idx  <= idx + IDXW'(1);
                beat <= beat + 8'd1;
                err  <= err_nx;
                if (w_last_beat) begin
                    S_AXI_BVALID <= 1'b1;
                    S_AXI_BID    <= id;
                    S_AXI_BRESP  <= (err_nx || oor) ? SLVERR : OKAY;
                end
            end
            if (b_hs) S_AXI_BVALID <= 1'b0;
            if (r_hs) begin
                if (S_AXI_RLAST) begin
                    S_AXI_RVALID <= 1'b0;
                    S_AXI_RLAST  <= 1'b0;
                end else begin
                    idx         <= idx + IDXW'(1);
                    beat        <= beat + 8'd1;
                    S_AXI_RDATA <= oor ? '0 : mem[idx];
                    S_AXI_RLAST <= ((beat + 8'd1) == len);
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave; expectations follow AXI_MEM_RANGE_CHECK_EN when it is defined.
module tb_axi_mem_slave;
    localparam int BOUND = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [3:0]  S_AXI_AWID = '0;
    logic [7:0]  S_AXI_AWLEN = '0;
    logic [2:0]  S_AXI_AWSIZE = '0;
    logic [1:0]  S_AXI_AWBURST = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [63:0] S_AXI_WDATA = '0;
    logic [7:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WLAST = 1'b0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic [3:0]  S_AXI_BID;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [3:0]  S_AXI_ARID = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic [2:0]  S_AXI_ARSIZE = '0;
    logic [1:0]  S_AXI_ARBURST = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [63:0] S_AXI_RDATA;
    logic [3:0]  S_AXI_RID;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    axi_mem_slave dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BID(S_AXI_BID), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RID(S_AXI_RID), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All drivers start just after a rising edge and return just after one.
    task automatic aw_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        int k;
        S_AXI_AWADDR = addr; S_AXI_AWID = id; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        k = 0;
        @(negedge clk);
        while (!S_AXI_AWREADY && k < BOUND) begin @(negedge clk); k++; end
        chk("aw_accept", 64'(k < BOUND), 64'd1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int k;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
        k = 0;
        @(negedge clk);
        while (!S_AXI_WREADY && k < BOUND) begin @(negedge clk); k++; end
        chk("w_accept", 64'(k < BOUND), 64'd1);
        @(posedge clk); #1;
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int k;
        S_AXI_BREADY = 1'b1;
        k = 0;
        @(negedge clk);
        while (!S_AXI_BVALID && k < BOUND) begin @(negedge clk); k++; end
        chk({tag, "_bvalid"}, 64'(S_AXI_BVALID), 64'd1);
        chk({tag, "_bid"}, 64'(S_AXI_BID), 64'(id));
        chk({tag, "_bresp"}, 64'(S_AXI_BRESP), 64'(resp));
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        int k;
        S_AXI_ARADDR = addr; S_AXI_ARID = id; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        k = 0;
        @(negedge clk);
        while (!S_AXI_ARREADY && k < BOUND) begin @(negedge clk); k++; end
        chk("ar_accept", 64'(k < BOUND), 64'd1);
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic r_recv(input string tag, input logic [63:0] data, input logic last,
                          input logic [1:0] resp, input logic [3:0] id);
        int k;
        S_AXI_RREADY = 1'b1;
        k = 0;
        @(negedge clk);
        while (!S_AXI_RVALID && k < BOUND) begin @(negedge clk); k++; end
        chk({tag, "_rvalid"}, 64'(S_AXI_RVALID), 64'd1);
        chk({tag, "_rdata"}, S_AXI_RDATA, data);
        chk({tag, "_rlast"}, 64'(S_AXI_RLAST), 64'(last));
        chk({tag, "_rresp"}, 64'(S_AXI_RRESP), 64'(resp));
        chk({tag, "_rid"}, 64'(S_AXI_RID), 64'(id));
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [63:0] wrap_a, wrap_b, alias_d;
        wrap_a  = 64'hA5A5_A5A5_0000_0001;
        wrap_b  = 64'h5A5A_5A5A_0000_0002;
        alias_d = 64'hDEAD_BEEF_0BAD_F00D;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_awready", 64'(S_AXI_AWREADY), 64'd1);
        chk("rst_arready", 64'(S_AXI_ARREADY), 64'd1);
        chk("rst_wready", 64'(S_AXI_WREADY), 64'd0);
        chk("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
        chk("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
        chk("rst_rlast", 64'(S_AXI_RLAST), 64'd0);
        chk("rst_rdata", S_AXI_RDATA, 64'd0);
        chk("rst_bid_rid", 64'({S_AXI_BID, S_AXI_RID}), 64'd0);
        chk("rst_resp", 64'({S_AXI_BRESP, S_AXI_RRESP}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-beat write then read
        aw_send(32'h10, 4'd3, 8'd0);
        w_send(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        b_recv("t1", 4'd3, 2'b00);
        ar_send(32'h10, 4'd5, 8'd0);
        r_recv("t1", 64'h1122_3344_5566_7788, 1'b1, 2'b00, 4'd5);

        // Four-beat write, partial overwrite of word 1, four-beat read
        aw_send(32'h0, 4'd1, 8'd3);
        for (int i = 1; i <= 4; i++) w_send(64'(i), 8'hFF, i == 4);
        b_recv("t2w", 4'd1, 2'b00);
        aw_send(32'h8, 4'd2, 8'd0);
        w_send(64'hFFFF_FFFF_AAAA_AAAA, 8'h0F, 1'b1);
        b_recv("t2p", 4'd2, 2'b00);
        ar_send(32'h0, 4'd4, 8'd3);
        r_recv("t2b0", 64'd1, 1'b0, 2'b00, 4'd4);
        r_recv("t2b1", 64'h0000_0000_AAAA_AAAA, 1'b0, 2'b00, 4'd4);
        r_recv("t2b2", 64'd3, 1'b0, 2'b00, 4'd4);
        r_recv("t2b3", 64'd4, 1'b1, 2'b00, 4'd4);

        // AW and AR raised together: write wins, read sees the new data
        S_AXI_ARADDR = 32'h100; S_AXI_ARID = 4'd7; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR = 32'h100; S_AXI_AWID = 4'd8; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        chk("t3_awready", 64'(S_AXI_AWREADY), 64'd1);
        chk("t3_arready_idle", 64'(S_AXI_ARREADY), 64'd0);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        @(negedge clk);
        chk("t3_arready_wdata", 64'(S_AXI_ARREADY), 64'd0);
        chk("t3_state_wdata", 64'(dbg_state), 64'd1);
        @(posedge clk); #1;
        w_send(64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1);
        @(negedge clk);
        chk("t3_arready_wresp", 64'(S_AXI_ARREADY), 64'd0);
        @(posedge clk); #1;
        b_recv("t3", 4'd8, 2'b00);
        ar_send(32'h100, 4'd7, 8'd0);
        r_recv("t3", 64'hCAFE_F00D_1234_5678, 1'b1, 2'b00, 4'd7);

        // Eight-beat read with RREADY stalls, then streaming
        aw_send(32'h200, 4'd6, 8'd7);
        for (int i = 0; i < 8; i++) w_send(64'h100 + 64'(i), 8'hFF, i == 7);
        b_recv("t4w", 4'd6, 2'b00);
        ar_send(32'h200, 4'd6, 8'd7);
        S_AXI_RREADY = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("t4_stall_data0", S_AXI_RDATA, 64'h100 + 64'(b));
            chk("t4_stall_valid", 64'(S_AXI_RVALID), 64'd1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("t4_stall_data1", S_AXI_RDATA, 64'h100 + 64'(b));
            chk("t4_stall_last", 64'(S_AXI_RLAST), 64'd0);
            @(posedge clk); #1;
            S_AXI_RREADY = 1'b1;
            @(negedge clk);
            chk("t4_stall_data2", S_AXI_RDATA, 64'h100 + 64'(b));
            @(posedge clk); #1;
            S_AXI_RREADY = 1'b0;
        end
        S_AXI_RREADY = 1'b1;
        for (int b = 4; b < 8; b++) begin
            @(negedge clk);
            chk("t4_stream_valid", 64'(S_AXI_RVALID), 64'd1);
            chk("t4_stream_data", S_AXI_RDATA, 64'h100 + 64'(b));
            chk("t4_stream_last", 64'(S_AXI_RLAST), 64'(b == 7));
        end
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
        @(negedge clk);
        chk("t4_done_valid", 64'(S_AXI_RVALID), 64'd0);
        chk("t4_done_last", 64'(S_AXI_RLAST), 64'd0);
        @(posedge clk); #1;

        // WLAST misuse: early WLAST, and missing WLAST on a single beat
        aw_send(32'h300, 4'd9, 8'd1);
        w_send(64'h11, 8'hFF, 1'b1);
        @(negedge clk);
        chk("t5_wready_after_early_wlast", 64'(S_AXI_WREADY), 64'd1);
        @(posedge clk); #1;
        w_send(64'h22, 8'hFF, 1'b1);
        b_recv("t5_early", 4'd9, 2'b10);
        aw_send(32'h308, 4'd10, 8'd0);
        w_send(64'h33, 8'hFF, 1'b0);
        b_recv("t5_missing", 4'd10, 2'b10);

        // Burst wraps from the last word to word 0
        aw_send(32'h1FF8, 4'd11, 8'd1);
        w_send(wrap_a, 8'hFF, 1'b0);
        w_send(wrap_b, 8'hFF, 1'b1);
        b_recv("t5_wrap", 4'd11, 2'b00);
        ar_send(32'h0, 4'd12, 8'd0);
        r_recv("t5_word0", wrap_b, 1'b1, 2'b00, 4'd12);
        ar_send(32'h1FF8, 4'd13, 8'd1);
        r_recv("t5_rwrap0", wrap_a, 1'b0, 2'b00, 4'd13);
        r_recv("t5_rwrap1", wrap_b, 1'b1, 2'b00, 4'd13);

        // Maximum-length burst (256 beats)
        aw_send(32'h1000, 4'd14, 8'd255);
        for (int i = 0; i < 256; i++) w_send(64'h5000 + 64'(i), 8'hFF, i == 255);
        b_recv("t_len255", 4'd14, 2'b00);
        ar_send(32'h1000, 4'd15, 8'd255);
        for (int i = 0; i < 256; i++) r_recv("t_len255", 64'h5000 + 64'(i), i == 255, 2'b00, 4'd15);

        // Reset in the middle of a write burst keeps beats already written
        aw_send(32'h400, 4'd1, 8'd3);
        w_send(64'h77, 8'hFF, 1'b0);
        w_send(64'h88, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 64'(dbg_state), 64'd0);
        chk("mid_rst_wready", 64'(S_AXI_WREADY), 64'd0);
        chk("mid_rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ar_send(32'h400, 4'd2, 8'd1);
        r_recv("mid_rst_b0", 64'h77, 1'b0, 2'b00, 4'd2);
        r_recv("mid_rst_b1", 64'h88, 1'b1, 2'b00, 4'd2);

        // Address one past the end of memory
`ifdef AXI_MEM_RANGE_CHECK_EN
        ar_send(32'h2000, 4'd3, 8'd0);
        r_recv("t6_read", 64'd0, 1'b1, 2'b10, 4'd3);
        aw_send(32'h2000, 4'd4, 8'd0);
        w_send(alias_d, 8'hFF, 1'b1);
        b_recv("t6_write", 4'd4, 2'b10);
        ar_send(32'h0, 4'd5, 8'd0);
        r_recv("t6_word0", wrap_b, 1'b1, 2'b00, 4'd5);
`else
        ar_send(32'h2000, 4'd3, 8'd0);
        r_recv("t6_read", wrap_b, 1'b1, 2'b00, 4'd3);
        aw_send(32'h2000, 4'd4, 8'd0);
        w_send(alias_d, 8'hFF, 1'b1);
        b_recv("t6_write", 4'd4, 2'b00);
        ar_send(32'h0, 4'd5, 8'd0);
        r_recv("t6_word0", alias_d, 1'b1, 2'b00, 4'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
